// File: rtl/dmem_wait_responder_pkg.sv
// Shared types and helpers for the wait-state data-memory responder.
package dmem_wait_responder_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_F000;

    typedef enum logic [1:0] {
        DRSP_IDLE = 2'b00,
        DRSP_WAIT = 2'b01,
        DRSP_RESP = 2'b10
    } drsp_state_e;

    // Captured request attributes
    typedef struct packed {
        logic       rd;
        logic       wr;
        logic [1:0] size;
    } dmem_op_t;

    // Byte enables for a write of the given size at the given lane offset
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SIZE_BYTE: be = 4'(4'b0001 << lane);
            SIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate LSB-aligned write data across every lane it may land in
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] d;
        d = data;
        case (size)
            SIZE_BYTE: d = {4{data[7:0]}};
            SIZE_HALF: d = {2{data[15:0]}};
            default:   d = data;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dmem_wait_array.sv
// Word-organised data memory: combinational read, byte-enabled synchronous write.
module dmem_wait_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_c_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    assign rdata_c_o = mem_q[idx_i];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_wait_responder.sv
// Single-outstanding dmem target: captures a request, waits LATENCY cycles,
// then pulses ready with data/err and commits any write on the closing edge.
module dmem_wait_responder
    import dmem_wait_responder_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       LATENCY     = 2,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(TOHOST_ADDR_DEF)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              r_enable_i,
    input  logic              w_enable_i,
    input  logic [1:0]        w_size_i,
    input  logic [DATA_W-1:0] w_data_i,
    output logic [DATA_W-1:0] r_data_o,
    output logic              ready_o,
    output logic              err_o,
    output logic              done_o
);

    localparam int unsigned       IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(4 * DEPTH_WORDS);

    drsp_state_e       state_q;
    logic [3:0]        cnt_q;
    dmem_op_t          op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ready_q;
    logic              err_q;
    logic              done_q;

    logic [ADDR_W-1:0] off_c;
    logic              in_range_c;
    logic              tohost_c;
    logic              misalign_c;
    logic              err_c;
    logic              store_c;
    logic              done_set_c;
    logic              we_c;
    logic [31:0]       arr_rdata_c;
    logic [31:0]       rword_c;

    // Error and target decode, all from the captured request
    always_comb begin
        off_c      = addr_q - BASE_ADDR;
        in_range_c = (addr_q >= BASE_ADDR) && (off_c < SPAN);
        tohost_c   = (addr_q[ADDR_W-1:2] == TOHOST_ADDR[ADDR_W-1:2]);
        misalign_c = ((op_q.size == SIZE_HALF) && addr_q[0]) ||
                     ((op_q.size == SIZE_WORD) && (addr_q[1:0] != 2'b00));
        err_c      = (op_q.rd && op_q.wr) ||
                     (op_q.wr && ((op_q.size == 2'b11) || misalign_c)) ||
                     (!in_range_c && !tohost_c) ||
                     (op_q.wr && tohost_c && (op_q.size != SIZE_WORD));
        store_c    = op_q.wr && !err_c && !tohost_c;
        done_set_c = op_q.wr && !err_c && tohost_c;
        we_c       = reset_i && (state_q == DRSP_RESP) && store_c;
        rword_c    = tohost_c ? {31'b0, done_q} : arr_rdata_c;
    end

    dmem_wait_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk_i     (clk_i),
        .we_i      (we_c),
        .be_i      (lane_be(op_q.size, addr_q[1:0])),
        .idx_i     (off_c[IDX_W+1:2]),
        .wdata_i   (lane_data(op_q.size, wdata_q)),
        .rdata_c_o (arr_rdata_c)
    );

    // Request FSM; ready/err/r_data are registered on entry to RESP
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= DRSP_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            case (state_q)
                DRSP_IDLE: begin
                    if (r_enable_i || w_enable_i) begin
                        op_q    <= '{rd: r_enable_i, wr: w_enable_i, size: w_size_i};
                        addr_q  <= addr_i;
                        wdata_q <= w_data_i;
                        cnt_q   <= 4'(LATENCY - 1);
                        state_q <= DRSP_WAIT;
                    end
                end
                DRSP_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= DRSP_RESP;
                        ready_q <= 1'b1;
                        err_q   <= err_c;
                        rdata_q <= (op_q.rd && !err_c) ? rword_c : '0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DRSP_RESP: begin
                    if (done_set_c) done_q <= 1'b1;
                    state_q <= DRSP_IDLE;
                end
                default: state_q <= DRSP_IDLE;
            endcase
        end
    end

    assign r_data_o = rdata_q;
    assign ready_o  = ready_q;
    assign err_o    = err_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed bench for dmem_wait_responder: LATENCY=2 instance for function,
// LATENCY=1 instance for back-to-back handshaking.
module tb_dmem_wait_responder;

    localparam int unsigned LAT_A = 2;
    localparam int unsigned LAT_B = 1;
    localparam int unsigned TMO   = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic        r_en = 1'b0;
    logic        w_en = 1'b0;
    logic [1:0]  w_size = 2'b00;
    logic [31:0] w_data = '0;
    logic [31:0] r_data;
    logic        ready, err, done;

    logic        r_en1 = 1'b0;
    logic        w_en1 = 1'b0;
    logic [31:0] r_data1;
    logic        ready1, err1, done1;
    int          ready1_cnt = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (ready1) ready1_cnt <= ready1_cnt + 1;

    dmem_wait_responder #(.LATENCY(LAT_A)) dut (
        .clk_i(clk), .reset_i(reset), .addr_i(addr), .r_enable_i(r_en),
        .w_enable_i(w_en), .w_size_i(w_size), .w_data_i(w_data),
        .r_data_o(r_data), .ready_o(ready), .err_o(err), .done_o(done)
    );

    dmem_wait_responder #(.LATENCY(LAT_B)) dut1 (
        .clk_i(clk), .reset_i(reset), .addr_i(addr), .r_enable_i(r_en1),
        .w_enable_i(w_en1), .w_size_i(w_size), .w_data_i(w_data),
        .r_data_o(r_data1), .ready_o(ready1), .err_o(err1), .done_o(done1)
    );

    // One transaction on dut; lat counts edges from driving the request to the ready cycle
    task automatic txn(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rdv, output logic erv);
        logic got;
        @(posedge clk); #1;
        addr = a; r_en = rd; w_en = wr; w_size = sz; w_data = d;
        lat = 0; rdv = 'x; erv = 1'bx; got = 1'b0;
        while (!got && lat < TMO) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (ready) begin got = 1'b1; rdv = r_data; erv = err; end
        end
        @(posedge clk); #1;
        r_en = 1'b0; w_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({ready, err, done} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {ready, err, done}); end
        checks++; if (r_data !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 00000000", r_data); end
        #1 reset = 1'b1;
    endtask

    task automatic test_word_rw();
        int lat; logic [31:0] rv; logic ev;
        txn(1'b0, 1'b1, 2'b10, 32'h10, 32'hCAFEBABE, lat, rv, ev);
        checks++; if (lat !== LAT_A + 1) begin errors++; $display("FAIL wr_latency got %0d want %0d", lat, LAT_A + 1); end
        checks++; if (ev !== 1'b0) begin errors++; $display("FAIL wr_err got %b want 0", ev); end
        txn(1'b1, 1'b0, 2'b10, 32'h10, 32'h0, lat, rv, ev);
        checks++; if (lat !== LAT_A + 1) begin errors++; $display("FAIL rd_latency got %0d want %0d", lat, LAT_A + 1); end
        checks++; if (rv !== 32'hCAFEBABE || ev !== 1'b0) begin errors++; $display("FAIL rd_word got %h/%b want cafebabe/0", rv, ev); end
    endtask

    task automatic test_lanes();
        int lat; logic [31:0] rv; logic ev;
        txn(1'b0, 1'b1, 2'b10, 32'h20, 32'h11223344, lat, rv, ev);
        txn(1'b0, 1'b1, 2'b00, 32'h22, 32'hFFFF_FFAA, lat, rv, ev);
        checks++; if (ev !== 1'b0) begin errors++; $display("FAIL byte_err got %b want 0", ev); end
        txn(1'b1, 1'b0, 2'b10, 32'h20, 32'h0, lat, rv, ev);
        checks++; if (rv !== 32'h11AA3344) begin errors++; $display("FAIL byte_lane got %h want 11aa3344", rv); end
        txn(1'b0, 1'b1, 2'b01, 32'h20, 32'hFFFF_BEEF, lat, rv, ev);
        txn(1'b1, 1'b0, 2'b10, 32'h20, 32'h0, lat, rv, ev);
        checks++; if (rv !== 32'h11AABEEF) begin errors++; $display("FAIL half_lane got %h want 11aabeef", rv); end
        txn(1'b1, 1'b0, 2'b10, 32'h23, 32'h0, lat, rv, ev);
        checks++; if (rv !== 32'h11AABEEF || ev !== 1'b0) begin errors++; $display("FAIL rd_unaligned got %h/%b want 11aabeef/0", rv, ev); end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rv; logic ev;
        txn(1'b0, 1'b1, 2'b01, 32'h21, 32'h0000_1234, lat, rv, ev);
        checks++; if (ev !== 1'b1 || lat !== LAT_A + 1) begin errors++; $display("FAIL half_misalign got err %b lat %0d want 1/%0d", ev, lat, LAT_A + 1); end
        txn(1'b0, 1'b1, 2'b10, 32'h22, 32'h5555_5555, lat, rv, ev);
        checks++; if (ev !== 1'b1) begin errors++; $display("FAIL word_misalign got %b want 1", ev); end
        txn(1'b1, 1'b1, 2'b10, 32'h20, 32'h6666_6666, lat, rv, ev);
        checks++; if (ev !== 1'b1 || rv !== 32'h0) begin errors++; $display("FAIL both_en got %b/%h want 1/00000000", ev, rv); end
        txn(1'b0, 1'b1, 2'b11, 32'h20, 32'h7777_7777, lat, rv, ev);
        checks++; if (ev !== 1'b1) begin errors++; $display("FAIL size11 got %b want 1", ev); end
        txn(1'b1, 1'b0, 2'b10, 32'h20, 32'h0, lat, rv, ev);
        checks++; if (rv !== 32'h11AABEEF || ev !== 1'b0) begin errors++; $display("FAIL err_nowrite got %h/%b want 11aabeef/0", rv, ev); end
    endtask

    task automatic test_range_tohost();
        int lat; logic [31:0] rv; logic ev;
        txn(1'b0, 1'b1, 2'b10, 32'h1000, 32'h1, lat, rv, ev);
        checks++; if (ev !== 1'b1) begin errors++; $display("FAIL wr_oob got %b want 1", ev); end
        txn(1'b1, 1'b0, 2'b10, 32'h1000, 32'h0, lat, rv, ev);
        checks++; if (ev !== 1'b1 || rv !== 32'h0) begin errors++; $display("FAIL rd_oob got %b/%h want 1/00000000", ev, rv); end
        txn(1'b0, 1'b1, 2'b00, 32'hF000, 32'h1, lat, rv, ev);
        checks++; if (ev !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL tohost_byte got err %b done %b want 1/0", ev, done); end
        txn(1'b1, 1'b0, 2'b10, 32'hF000, 32'h0, lat, rv, ev);
        checks++; if (rv !== 32'h0 || ev !== 1'b0) begin errors++; $display("FAIL tohost_rd0 got %h/%b want 00000000/0", rv, ev); end
        txn(1'b0, 1'b1, 2'b10, 32'hF000, 32'h1, lat, rv, ev);
        checks++; if (ev !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL tohost_wr got err %b done %b want 0/1", ev, done); end
        txn(1'b1, 1'b0, 2'b10, 32'hF000, 32'h0, lat, rv, ev);
        checks++; if (rv !== 32'h1) begin errors++; $display("FAIL tohost_rd1 got %h want 00000001", rv); end
        for (int i = 0; i < 10; i++) begin
            txn(1'b1, 1'b0, 2'b10, 32'h10, 32'h0, lat, rv, ev);
            checks++; if (done !== 1'b1 || rv !== 32'hCAFEBABE) begin errors++; $display("FAIL done_sticky[%0d] got %b/%h want 1/cafebabe", i, done, rv); end
        end
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] rv; logic ev; int seen;
        txn(1'b0, 1'b1, 2'b10, 32'h30, 32'h12345678, lat, rv, ev);
        @(posedge clk); #1;
        addr = 32'h30; w_en = 1'b1; w_size = 2'b00; w_data = 32'h55;
        @(posedge clk); #1;
        reset = 1'b0; w_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        seen = 0;
        repeat (6) begin @(negedge clk); if (ready) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_ready got %0d pulses want 0", seen); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
        txn(1'b1, 1'b0, 2'b10, 32'h30, 32'h0, lat, rv, ev);
        checks++; if (rv !== 32'h12345678) begin errors++; $display("FAIL abort_nowrite got %h want 12345678", rv); end
    endtask

    task automatic test_back_to_back();
        int lat; logic got; int base;
        base = ready1_cnt;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            addr = 32'h40 + 32'(4 * i); r_en1 = 1'b1;
            lat = 0; got = 1'b0;
            while (!got && lat < TMO) begin
                @(posedge clk); lat++;
                @(negedge clk);
                if (ready1) got = 1'b1;
            end
            checks++; if (lat !== LAT_B + 1) begin errors++; $display("FAIL b2b_latency[%0d] got %0d want %0d", i, lat, LAT_B + 1); end
            @(posedge clk); #1;
            r_en1 = 1'b0;
            @(negedge clk);
            checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL b2b_pulse[%0d] got %b want 0", i, ready1); end
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++; if (ready1_cnt - base !== 8) begin errors++; $display("FAIL b2b_count got %0d want 8", ready1_cnt - base); end
        checks++; if (err1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL b2b_flags got %b%b want 00", err1, done1); end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_lanes();
        test_errors();
        test_range_tohost();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
